// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the synchronous/asynchronous FIFO family: pointer width
// derivation and threshold sanity checking.
package sync_fifo_pkg;

    // Pointers and level carry one extra bit so full and empty stay distinguishable.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit thresh_ok(input int unsigned addr_width,
                                     input int unsigned afull_thresh,
                                     input int unsigned aempty_thresh);
        int unsigned depth;
        depth = 1 << addr_width;
        return (afull_thresh >= 1) && (afull_thresh <= depth) && (aempty_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one combinational
// read port, no reset.
module fifo_regfile #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Show-ahead synchronous FIFO with level output and almost-full/almost-empty flags.
// Define SYNC_FIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned AFULL_THRESH  = 12,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level
`ifdef SYNC_FIFO_ERR_FLAG_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int unsigned PW    = ptr_width(ADDR_WIDTH);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    if (!thresh_ok(ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("sync_fifo_flags: AFULL_THRESH/AEMPTY_THRESH out of range");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_q, level_d;
    logic                  push_ok, pop_ok;
    logic [DATA_WIDTH-1:0] rdata;

    assign empty        = (level_q == '0);
    assign full         = (level_q == PW'(DEPTH));
    assign almost_empty = (level_q <= PW'(AEMPTY_THRESH));
    assign almost_full  = (level_q >= PW'(AFULL_THRESH));
    assign level        = level_q;
    assign data_out     = empty ? '0 : rdata;

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok) begin
                level_d = level_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    fifo_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_regfile (
        .clk_i  (clk),
        .we_i   (push_ok & ~clear),
        .waddr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i(data_in),
        .raddr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o(rdata)
    );

`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && full && !pop) overflow_q  <= 1'b1;
            if (pop && empty)         underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    a_level_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        level_q == PW'(wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised and directed self-checking bench for sync_fifo_flags (DEPTH=4),
// compared against a queue-based reference model.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       empty, full, almost_empty, almost_full;
    logic [2:0] level;
`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic       overflow, underflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];
    bit         ovf_m = 1'b0;
    bit         unf_m = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (2),
        .AFULL_THRESH (3),
        .AEMPTY_THRESH(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .level       (level)
`ifdef SYNC_FIFO_ERR_FLAG_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    // {data_out, level, empty, full, almost_empty, almost_full, overflow, underflow}
    function automatic logic [16:0] model_status();
        int         n;
        logic [7:0] head;
        logic [1:0] err;
        n    = mq.size();
        head = 8'h00;
        if (n != 0) head = mq[0];
        err = 2'b00;
`ifdef SYNC_FIFO_ERR_FLAG_EN
        err = {ovf_m, unf_m};
`endif
        return {head, 3'(n), n == 0, n == 4, n <= 1, n >= 3, err};
    endfunction

    function automatic logic [16:0] dut_status();
        logic [1:0] err;
        err = 2'b00;
`ifdef SYNC_FIFO_ERR_FLAG_EN
        err = {overflow, underflow};
`endif
        return {data_out, level, empty, full, almost_empty, almost_full, err};
    endfunction

    task automatic model_reset();
        mq.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    // Drive one cycle and advance the reference model on the same edge.
    task automatic cycle(input logic p, input logic q, input logic c, input logic [7:0] d);
        bit was_full, was_empty, pop_acc, push_acc;
        push    = p;
        pop     = q;
        clear   = c;
        data_in = d;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            was_full  = (mq.size() == 4);
            was_empty = (mq.size() == 0);
            if (p && was_full && !q) ovf_m = 1'b1;
            if (q && was_empty)      unf_m = 1'b1;
            pop_acc  = q && !was_empty;
            push_acc = p && (!was_full || pop_acc);
            if (pop_acc)  void'(mq.pop_front());
            if (push_acc) mq.push_back(d);
        end
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] obs, expv;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        obs = dut_status(); expv = model_status(); n_tests++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL reset status got %h want %h", obs, expv);
        end
        n_tests++;
        if (level !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || data_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_values got lvl=%0d e=%b ae=%b d=%h want 0 1 1 00",
                               level, empty, almost_empty, data_out);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        logic [16:0] obs, expv;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'hA1 + 8'(i));
            obs = dut_status(); expv = model_status(); n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL fill[%0d] status got %h want %h", i, obs, expv);
            end
            n_tests++;
            if (level !== 3'(i + 1) || data_out !== 8'hA1) begin
                n_fail++; $display("FAIL fill_lvl[%0d] got lvl=%0d d=%h want %0d A1",
                                   i, level, data_out, i + 1);
            end
        end
        n_tests++;
        if (full !== 1'b1 || almost_full !== 1'b1 || almost_empty !== 1'b0) begin
            n_fail++; $display("FAIL fill_flags got f=%b af=%b ae=%b want 1 1 0",
                               full, almost_full, almost_empty);
        end
    endtask

    task automatic test_overflow_drain();
        logic [16:0] obs, expv;
        cycle(1'b1, 1'b0, 1'b0, 8'hB5);
        n_tests++;
        if (level !== 3'd4 || data_out !== 8'hA1) begin
            n_fail++; $display("FAIL ovf_drop got lvl=%0d d=%h want 4 A1", level, data_out);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (data_out !== 8'hA1 + 8'(i)) begin
                n_fail++; $display("FAIL drain[%0d] got %h want %h", i, data_out, 8'hA1 + 8'(i));
            end
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
        end
        obs = dut_status(); expv = model_status(); n_tests++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL drain_end status got %h want %h", obs, expv);
        end
`ifdef SYNC_FIFO_ERR_FLAG_EN
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_sticky got %b want 1", overflow);
        end
`endif
    endtask

    task automatic test_full_push_pop();
        logic [16:0] obs, expv;
        logic [7:0]  want [4];
        want[0] = 8'hA2; want[1] = 8'hA3; want[2] = 8'hA4; want[3] = 8'hC0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'hA1 + 8'(i));
        cycle(1'b1, 1'b1, 1'b0, 8'hC0);
        n_tests++;
        if (level !== 3'd4) begin
            n_fail++; $display("FAIL full_pp_lvl got %0d want 4", level);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (data_out !== want[i]) begin
                n_fail++; $display("FAIL full_pp_pop[%0d] got %h want %h", i, data_out, want[i]);
            end
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
        end
        obs = dut_status(); expv = model_status(); n_tests++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL full_pp_end status got %h want %h", obs, expv);
        end
    endtask

    task automatic test_empty_push_pop();
        logic [16:0] obs, expv;
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        n_tests++;
        if (level !== 3'd1 || data_out !== 8'h55) begin
            n_fail++; $display("FAIL empty_pp got lvl=%0d d=%h want 1 55", level, data_out);
        end
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        obs = dut_status(); expv = model_status(); n_tests++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL empty_pop status got %h want %h", obs, expv);
        end
`ifdef SYNC_FIFO_ERR_FLAG_EN
        n_tests++;
        if (underflow !== 1'b1) begin
            n_fail++; $display("FAIL underflow_sticky got %b want 1", underflow);
        end
`endif
    endtask

    task automatic test_wrap();
        int next_out = 0;
        bit do_pop;
        for (int i = 0; i < 14; i++) begin
            do_pop = (mq.size() >= 2) || (i >= 10 && mq.size() != 0);
            if (do_pop) begin
                n_tests++;
                if (data_out !== 8'(next_out)) begin
                    n_fail++; $display("FAIL wrap_order[%0d] got %h want %h",
                                       next_out, data_out, 8'(next_out));
                end
                next_out++;
            end
            cycle(i < 10, do_pop, 1'b0, 8'(i));
            n_tests++;
            if (level > 3'd4 || level !== 3'(mq.size())) begin
                n_fail++; $display("FAIL wrap_lvl[%0d] got %0d want %0d", i, level, mq.size());
            end
        end
        n_tests++;
        if (next_out != 10 || empty !== 1'b1) begin
            n_fail++; $display("FAIL wrap_count got %0d empty=%b want 10 1", next_out, empty);
        end
    endtask

    task automatic test_clear_and_async_reset();
        logic [16:0] obs, expv;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
        cycle(1'b1, 1'b0, 1'b1, 8'h77);
        obs = dut_status(); expv = model_status(); n_tests++;
        if (obs !== expv || level !== 3'd0 || data_out !== 8'h00) begin
            n_fail++; $display("FAIL clear status got %h want %h", obs, expv);
        end
        cycle(1'b1, 1'b0, 1'b0, 8'h41);
        cycle(1'b1, 1'b1, 1'b0, 8'h42);
        push    = 1'b1;
        data_in = 8'h43;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        obs = dut_status(); expv = model_status(); n_tests++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL async_reset status got %h want %h", obs, expv);
        end
        push = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [16:0] obs, expv;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 3, 8'($urandom));
            obs = dut_status(); expv = model_status(); n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL random[%0d] status got %h want %h", i, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap();
        test_clear_and_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO and successor to the basic team FIFO. It uses all 2**ADDR_WIDTH entries and supports a simultaneous push and pop in the same cycle. Adds guarded overflow/underflow, a fill-level output, and programmable almost-full/almost-empty flags. Sits between same-clock producer/consumer pipelines as the standard elastic buffer; read data is show-ahead (first-word-fall-through).

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
ADDR_WIDTH, 4, pointer width; FIFO depth DEPTH = 2**ADDR_WIDTH (>=1)
AFULL_THRESH, 12, almost_full asserts when level >= AFULL_THRESH (1..DEPTH)
AEMPTY_THRESH, 2, almost_empty asserts when level <= AEMPTY_THRESH (0..DEPTH-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush; highest priority after reset
push  input  1  write request
pop  input  1  read request
data_in  input  DATA_WIDTH  write data, sampled on accepted push
data_out  output  DATA_WIDTH  head-of-FIFO word; zero when empty
empty  output  1  level == 0
full  output  1  level == DEPTH
almost_empty  output  1  level <= AEMPTY_THRESH
almost_full  output  1  level >= AFULL_THRESH
level  output  ADDR_WIDTH+1  current number of stored words

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, async): pointers and level go to 0. Outputs: empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_THRESH>=1), level=0, data_out=0. Storage array is not reset.
- Pointers are ADDR_WIDTH+1 bits with an extra wrap bit. Address is the low ADDR_WIDTH bits, and pointers wrap naturally modulo 2*DEPTH. level is a registered counter and must always equal wr_ptr - rd_ptr (mod 2*DEPTH).
- Accept rules, evaluated on the same edge:
  - push_ok = push & (~full | pop_ok)
  - pop_ok = pop & ~empty
- Full with push+pop: both accepted. Head is read, new word is written at the tail, level is unchanged.
- Empty with push+pop: pop ignored, push accepted, level becomes 1.
- Push while full without pop: dropped; no pointer, level or memory change.
- Pop while empty: ignored.
- Level update: level +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Read latency: a word written at edge N appears on data_out after edge N if the FIFO was empty. data_out = mem[rd_ptr] combinationally from registered state, forced to 0 when empty.
- Status flags are combinational decodes of the registered level; no extra latency beyond level.
- clear=1 on an edge:
  - rd_ptr, wr_ptr and level go to 0.
  - push/pop in the same cycle are ignored.
  - Memory is untouched.
- Reset asserted mid-operation aborts everything immediately. Contents are considered lost.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAG_EN.
- Defined: adds output ports overflow (1) and underflow (1), both sticky.
  - overflow sets on any edge with push & full & ~pop.
  - underflow sets on any edge with pop & empty.
  - Both clear on rst_n=0 or clear=1.
- Undefined: those ports and their registers do not exist; dropped requests are silently ignored.

Decomposition:
- Package sync_fifo_pkg holds a constant function for pointer/level width derivation and a parameter sanity check (thresholds within range). It is shared by later async/multichannel FIFOs.
- One sub-module, fifo_regfile: a DEPTH x DATA_WIDTH register array with one synchronous write port and one combinational read port, no reset.
- Pointer, level and flag logic stays in sync_fifo_flags.

Test Plan:
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH=4), AFULL_THRESH=3, AEMPTY_THRESH=1.
1. Reset, then push 0xA1,0xA2,0xA3,0xA4 on 4 cycles -> level 1,2,3,4. data_out=0xA1 after first edge. almost_full at level 3. full at level 4, where almost_empty=0.
2. From full, push 0xB5 with no pop -> dropped, level stays 4. Then pop 4 times -> data_out sequence 0xA1..0xA4, then empty=1, data_out=0. With SYNC_FIFO_ERR_FLAG_EN, overflow=1 and stays set.
3. From full, push 0xC0 and pop together -> level stays 4. Next four pops return 0xA2,0xA3,0xA4,0xC0.
4. Empty FIFO, push 0x55 and pop together -> level 1, data_out=0x55. Pop alone on empty -> no change. Underflow sets if the macro is defined.
5. Run 10 push/pop-interleaved words 0x00..0x09 through the FIFO, crossing the pointer wrap twice -> output order preserved and level never exceeds 4.
6. Hold 3 words; pulse clear together with push -> next cycle level=0, empty=1, data_out=0, error flags cleared. Assert rst_n=0 mid-push -> all outputs at reset values without a clock edge.
